// File: rtl/counter_sched_pkg.sv
// Shared types, defaults and round-robin helper for the counter scheduler.
package counter_sched_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    DONE
  } state_t;

  // Next winner after ptr, searching ptr+1, ptr+2, ... mod n; returns ptr if no request.
  // Descending scan with overwrite leaves the nearest requester without a break.
  function automatic int unsigned rr_next(input logic [7:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    logic [7:0]  sh;
    int unsigned idx;
    rr_next = ptr;
    for (int unsigned k = n; k >= 1; k--) begin
      idx = (ptr + k) % n;
      sh  = req >> idx;
      if (sh[0]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin select: one-hot winner and its index, searching from ptr+1.
module rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    idx    = IDX_W'(rr_next(8'(req), 32'(ptr), NUM_REQ));
    winner = '0;
    if (|req) winner = NUM_REQ'(1) << idx;
  end

endmodule

// File: rtl/counter_scheduler.sv
// Shares one up-counting timer among NUM_REQ requesters with round-robin ownership,
// latched interval length, abort, and a one-cycle completion pulse to the owner.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_out,
  output logic [NUM_REQ-1:0]       done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   ptr, ptr_nx;
  logic [IDX_W-1:0]   win_q, win_nx;
  logic [CNT_W-1:0]   len_q, len_q_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [NUM_REQ-1:0] grant_nx, done_nx;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic [CNT_W-1:0]   len_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (arb_onehot),
    .idx    (arb_idx)
  );

  always_comb begin
    len_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) len_sel = len[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= IDX_W'(NUM_REQ - 1);
      win_q <= '0;
      len_q <= '0;
      cnt   <= '0;
      grant <= '0;
      done  <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      win_q <= win_nx;
      len_q <= len_q_nx;
      cnt   <= cnt_nx;
      grant <= grant_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    win_nx   = win_q;
    len_q_nx = len_q;
    cnt_nx   = cnt;
    grant_nx = grant;
    done_nx  = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = LOAD;
          grant_nx = arb_onehot;
          win_nx   = arb_idx;
          len_q_nx = len_sel;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx = IDLE;
          grant_nx = '0;
          ptr_nx   = win_q;
        end else begin
          state_nx = COUNT;
          cnt_nx   = '0;
        end
      end
      COUNT: begin
        // abort wins over terminal count so an aborted interval never pulses done
        if (abort) begin
          state_nx = IDLE;
          grant_nx = '0;
          ptr_nx   = win_q;
        end else if (cnt == len_q) begin
          state_nx = DONE;
          done_nx  = grant;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        grant_nx = '0;
        ptr_nx   = win_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign cnt_out = cnt;

endmodule

// File: tb/tb_counter_scheduler.sv
// Table-driven scoreboard bench for counter_scheduler (NUM_REQ=4, CNT_W=4).
module tb_counter_scheduler;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req   = '0;
  logic [15:0] len   = '0;
  logic        abort = 1'b0;
  logic [3:0]  grant, done, cnt_out;
  logic        busy;

  counter_scheduler #(
    .NUM_REQ (4),
    .CNT_W   (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .len     (len),
    .abort   (abort),
    .grant   (grant),
    .busy    (busy),
    .cnt_out (cnt_out),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic       busy;
    logic [3:0] cnt;
    logic       chk_cnt;
    logic [3:0] done;
  } exp_t;

  typedef struct {
    string       nm;
    bit          rst_before;
    logic [3:0]  req;
    logic [15:0] len;
    int          abort_at;
    bit          drop;
    int          win;
    int          l;
  } vec_t;

  exp_t       sb[$];
  vec_t       tv[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] last_cnt = '0;
  bit         last_known = 1'b1;

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string nm, input int e);
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s e%0d: got empty scoreboard expected an entry", nm, e);
      return;
    end
    x = sb.pop_front();
    chk4($sformatf("%s e%0d grant", nm, e), grant, x.grant);
    chk4($sformatf("%s e%0d busy", nm, e), {3'b0, busy}, {3'b0, x.busy});
    chk4($sformatf("%s e%0d done", nm, e), done, x.done);
    if (x.chk_cnt) chk4($sformatf("%s e%0d cnt", nm, e), cnt_out, x.cnt);
  endtask

  // Expected outputs come from the edge-numbered timing: e=1 grant, e=2+k cnt=k,
  // e=3+L done, e=4+L idle; abort seen at edge 3+A drops to idle.
  task automatic run_interval(input string nm, input logic [3:0] r, input logic [15:0] l,
                              input int abort_at, input bit drop, input int w, input int ln);
    logic [3:0] oh;
    int         n;
    oh = 4'd1 << w;
    n  = (abort_at >= 0) ? abort_at + 3 : ln + 4;
    for (int e = 1; e <= n; e++) begin
      exp_t x;
      x.grant   = oh;
      x.busy    = 1'b1;
      x.done    = '0;
      x.chk_cnt = 1'b1;
      x.cnt     = 4'(e - 2);
      if (e == 1) begin
        x.cnt     = last_cnt;
        x.chk_cnt = last_known;
      end
      if (abort_at >= 0 && e == n) begin
        x.grant   = '0;
        x.busy    = 1'b0;
        x.chk_cnt = 1'b0;
      end else if (abort_at < 0 && e == ln + 3) begin
        x.cnt  = 4'(ln);
        x.done = oh;
      end else if (abort_at < 0 && e == ln + 4) begin
        x.cnt   = 4'(ln);
        x.grant = '0;
        x.busy  = 1'b0;
      end
      sb.push_back(x);
    end
    req = r;
    len = l;
    for (int e = 1; e <= n; e++) begin
      tick();
      compare(nm, e);
      if (e == 1 && drop) begin
        req = '0;
        len = 16'hFFFF;
      end
      abort = (abort_at >= 0 && e == abort_at + 2);
    end
    abort      = 1'b0;
    last_cnt   = 4'(ln);
    last_known = (abort_at < 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b1111;
    repeat (2) tick();
    chk4("rst grant", grant, 4'b0000);
    chk4("rst busy", {3'b0, busy}, 4'b0000);
    chk4("rst done", done, 4'b0000);
    chk4("rst cnt", cnt_out, 4'b0000);
    reset      = 1'b1;
    req        = '0;
    last_cnt   = '0;
    last_known = 1'b1;
  endtask

  initial begin
    tv.push_back('{"rr0",      1'b1, 4'b1111, 16'h1111, -1, 1'b0, 0, 1});
    tv.push_back('{"rr1",      1'b0, 4'b1111, 16'h1111, -1, 1'b0, 1, 1});
    tv.push_back('{"rr2",      1'b0, 4'b1111, 16'h1111, -1, 1'b0, 2, 1});
    tv.push_back('{"rr3",      1'b0, 4'b1111, 16'h1111, -1, 1'b0, 3, 1});
    tv.push_back('{"rr4",      1'b0, 4'b1111, 16'h1111, -1, 1'b0, 0, 1});
    tv.push_back('{"single",   1'b1, 4'b0001, 16'h0003, -1, 1'b1, 0, 3});
    tv.push_back('{"zero",     1'b0, 4'b0100, 16'h0000, -1, 1'b0, 2, 0});
    tv.push_back('{"abort",    1'b0, 4'b0010, 16'h00A0,  5, 1'b0, 1, 10});
    tv.push_back('{"postabrt", 1'b0, 4'b1111, 16'h2222, -1, 1'b0, 2, 2});
    tv.push_back('{"maxlen",   1'b0, 4'b1000, 16'hF000, -1, 1'b0, 3, 15});

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst_before) do_reset();
      run_interval(tv[i].nm, tv[i].req, tv[i].len, tv[i].abort_at, tv[i].drop,
                   tv[i].win, tv[i].l);
      req = '0;
    end

    // Reset mid-count: len=15, reset at cnt=7 clears outputs without a clock edge.
    do_reset();
    req = 4'b0001;
    len = 16'h000F;
    repeat (9) tick();
    chk4("midrst pre cnt", cnt_out, 4'd7);
    chk4("midrst pre grant", grant, 4'b0001);
    #2;
    reset = 1'b0;
    #1;
    chk4("midrst grant", grant, 4'b0000);
    chk4("midrst busy", {3'b0, busy}, 4'b0000);
    chk4("midrst done", done, 4'b0000);
    chk4("midrst cnt", cnt_out, 4'b0000);
    req = 4'b1111;
    tick();
    reset      = 1'b1;
    last_cnt   = '0;
    last_known = 1'b1;
    run_interval("postrst", 4'b1111, 16'h2222, -1, 1'b0, 0, 2);
    req = '0;

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: got %0d leftover expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
